// File: rtl/pattern_pkg.sv
// ---------------------------------------------------------------------------
// pattern_pkg
//
// Shared definitions for the serial 1-0-0-1-0 pattern detector.
// Holds the 6-bit state type and the one-hot state codes that the
// pattern module uses as its parameter defaults.
//
// Contents:
//   state_t        6-bit one-hot state vector type
//   PAT_S_R        idle / nothing matched
//   PAT_S_1        "1" matched
//   PAT_S_10       "10" matched
//   PAT_S_100      "100" matched
//   PAT_S_1001     "1001" matched
//   PAT_S_10010    full pattern "10010" detected
// ---------------------------------------------------------------------------
package pattern_pkg;

    typedef logic [5:0] state_t;

    localparam state_t PAT_S_R     = 6'b000001;
    localparam state_t PAT_S_1     = 6'b000010;
    localparam state_t PAT_S_10    = 6'b000100;
    localparam state_t PAT_S_100   = 6'b001000;
    localparam state_t PAT_S_1001  = 6'b010000;
    localparam state_t PAT_S_10010 = 6'b100000;

endpackage

// File: rtl/pattern.sv
// ---------------------------------------------------------------------------
// pattern
//
// Moore FSM that watches a serial bit stream and flags the pattern
// 1-0-0-1-0 (first bit earliest).  One bit is consumed on every rising
// clock edge where valid is high; while valid is low the state holds and
// the data bit is ignored.  The state register is one-hot; any value that
// is not one of the six legal codes falls back to idle on the next edge.
//
// Configuration macro:
//   PATTERN_OVERLAP_EN  when defined, the tail "10" of a detected pattern
//                       is reused so "10010010" reports two hits; when
//                       undefined, detection is non-overlapping and five
//                       fresh bits are needed after every hit.
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst    in   1  synchronous, active-high reset (to idle, out=0)
//   in     in   1  serial data bit, sampled only when valid=1
//   valid  in   1  qualifies in
//   out    out  1  high exactly while the FSM sits in the detected state
// ---------------------------------------------------------------------------
module pattern
    import pattern_pkg::*;
#(
    parameter state_t S_R     = PAT_S_R,
    parameter state_t S_1     = PAT_S_1,
    parameter state_t S_10    = PAT_S_10,
    parameter state_t S_100   = PAT_S_100,
    parameter state_t S_1001  = PAT_S_1001,
    parameter state_t S_10010 = PAT_S_10010
)
(
    input  logic clk,
    input  logic rst,
    input  logic in,
    input  logic valid,
    output logic out
);

    state_t state;
    state_t nextState;

    // State register.  Reset wins over everything else so a partial match
    // in progress is thrown away.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_R;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic.  Each legal state either holds (valid low) or
    // follows the pattern-matching transition for the incoming bit, falling
    // back to the longest prefix of 10010 that is still a suffix of what has
    // been seen.  Anything that is not a legal one-hot code lands in the
    // default branch and recovers to idle regardless of valid.
    always_comb begin
        nextState = S_R;
        case (state)
            S_R:     nextState = valid ? (in ? S_1    : S_R)    : state;
            S_1:     nextState = valid ? (in ? S_1    : S_10)   : state;
            S_10:    nextState = valid ? (in ? S_1    : S_100)  : state;
            S_100:   nextState = valid ? (in ? S_1001 : S_R)    : state;
            S_1001:  nextState = valid ? (in ? S_1    : S_10010) : state;
`ifdef PATTERN_OVERLAP_EN
            // The trailing "10" of a hit is kept, so a following 0 already
            // gives "100".
            S_10010: nextState = valid ? (in ? S_1    : S_100)  : state;
`else
            // A hit consumes all five bits; matching restarts from scratch.
            S_10010: nextState = valid ? (in ? S_1    : S_R)    : state;
`endif
            default: nextState = S_R;
        endcase
    end

    // Moore output: a pure decode of the state register, so there is no
    // path from in or valid to out.
    assign out = (state == S_10010);

endmodule

// File: tb/tb_pattern.sv
// ---------------------------------------------------------------------------
// tb_pattern
//
// Self-checking bench for the pattern detector.  A sliding-window model of
// the bit stream predicts out on every cycle; directed sequences pin the
// model and the detector with hand-derived values, and randomized streams
// are counted against a greedy scan of the recorded bits.
// Honours PATTERN_OVERLAP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_pattern;
    import pattern_pkg::*;

    logic clk;
    logic rst;
    logic in;
    logic valid;
    logic out;

    int total;
    int bad;
    int riseCount;

    // Model state: last five consumed bits, number of bits eligible to be
    // part of the next match, and the predicted output.
    logic [4:0] hist;
    int         fresh;
    logic       expOut;
    logic       modelValid;
    logic       prevOut;

    bit         overlapMode;

    pattern dut (
        .clk   (clk),
        .rst   (rst),
        .in    (in),
        .valid (valid),
        .out   (out)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural reference: out is high after an edge exactly when the
    // last five consumed bits spell 10010 and none of them was already used
    // by an earlier hit (in non-overlapping mode).  Idle cycles change
    // nothing.
    always @(posedge clk) begin
        if (rst) begin
            hist       = 5'b0;
            fresh      = 0;
            expOut     = 1'b0;
            modelValid = 1'b1;
        end else if (valid) begin
            hist   = {hist[3:0], in};
            fresh  = fresh + 1;
            expOut = (fresh >= 5) && (hist == 5'b10010);
            if (expOut && !overlapMode) begin
                fresh = 0;
            end
        end
    end

    // Compare against the model on every falling edge once a reset has been
    // seen, and count rising edges of out for the stream-level checks.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("model", expOut);
            if (out && !prevOut) begin
                riseCount = riseCount + 1;
            end
            prevOut = out;
        end
    end

    // Drive one cycle of inputs, let the edge happen, then return just after
    // it so out already reflects that edge.
    task automatic applyStimulus(input logic b, input logic v, input logic r);
        rst   = r;
        valid = v;
        in    = b;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic expected);
        total = total + 1;
        if (out !== expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: out=%b expected=%b at %0t", name, out, expected, $time);
        end
    endtask

    task automatic checkIdleState(input string name);
        total = total + 1;
        if (dut.state !== PAT_S_R) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: state=%b expected=%b", name, dut.state, PAT_S_R);
        end
    endtask

    task automatic checkCount(input string name, input int actual, input int expected);
        total = total + 1;
        if (actual != expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: count=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Feed a short stream with valid held high, MSB of the vector first.
    task automatic sendBits(input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(bits[i], 1'b1, 1'b0);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    // Greedy left-to-right scan for 10010 in a recorded stream.
    function automatic int countHits(input logic bits[], input bit overlap);
        int i;
        int hits;
        hits = 0;
        i    = 0;
        while (i + 5 <= bits.size()) begin
            if (bits[i] == 1'b1 && bits[i+1] == 1'b0 && bits[i+2] == 1'b0 &&
                bits[i+3] == 1'b1 && bits[i+4] == 1'b0) begin
                hits = hits + 1;
                i    = overlap ? i + 3 : i + 5;
            end else begin
                i = i + 1;
            end
        end
        return hits;
    endfunction

    initial begin
        int   snap;
        int   expHits;
        logic randBits[];

        total       = 0;
        bad         = 0;
        riseCount   = 0;
        modelValid  = 1'b0;
        prevOut     = 1'b0;
        hist        = 5'b0;
        fresh       = 0;
        expOut      = 1'b0;
`ifdef PATTERN_OVERLAP_EN
        overlapMode = 1'b1;
`else
        overlapMode = 1'b0;
`endif
        rst   = 1'b0;
        valid = 1'b0;
        in    = 1'b0;

        // Reset for two edges with nothing else going on.
        $display("[TB] reset");
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("reset_out", 1'b0);
        checkIdleState("reset_state");

        // Single pattern: out only after the fifth bit, for one cycle.
        $display("[TB] single pattern");
        doReset();
        sendBits(8'b0000_1001, 4);
        checkOutput("single_before_fifth", 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("single_hit", 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("single_after", 1'b0);

        // 10010010: one hit when non-overlapping, two when overlapping.
        $display("[TB] overlap stream");
        doReset();
        snap = riseCount;
        sendBits(8'b1001_0010, 8);
`ifdef PATTERN_OVERLAP_EN
        checkOutput("overlap_last_bit", 1'b1);
`else
        checkOutput("overlap_last_bit", 1'b0);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0);
        expHits = overlapMode ? 2 : 1;
        checkCount("overlap_hits", riseCount - snap, expHits);

        // Gaps with valid low are ignored, even with in toggling.
        $display("[TB] gapped stream");
        doReset();
        sendBits(8'b0000_0010, 2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'bx, 1'b0, 1'b0);
        checkOutput("gap_no_hit", 1'b0);
        sendBits(8'b0000_0010, 3);
        checkOutput("gap_hit", 1'b1);
        // A held valid=0 keeps the detection visible.
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("gap_hold1", 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("gap_hold2", 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("gap_release", 1'b0);

        // Reset in the middle of a pattern discards the partial match.
        $display("[TB] mid-pattern reset");
        doReset();
        sendBits(8'b0000_1001, 4);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("midreset_out", 1'b0);
        checkIdleState("midreset_state");
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("midreset_next", 1'b0);

        // 500 random bits with valid held high.
        $display("[TB] random valid stream");
        doReset();
        randBits = new[500];
        snap = riseCount;
        for (int i = 0; i < 500; i++) begin
            randBits[i] = 1'($urandom_range(0, 1));
            applyStimulus(randBits[i], 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkCount("random_hits", riseCount - snap, countHits(randBits, overlapMode));

        // Mixed random traffic: valid gaps, unknown data while idle and the
        // odd reset, all tracked by the per-cycle model.
        $display("[TB] random mixed traffic");
        for (int i = 0; i < 600; i++) begin
            logic v;
            logic b;
            logic r;
            v = ($urandom_range(0, 3) != 0);
            b = v ? 1'($urandom_range(0, 1)) : 1'bx;
            r = ($urandom_range(0, 63) == 0);
            applyStimulus(b, v, r);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pattern.md
PATTERN -- requirements
Module: pattern

Interface
REQ-001 Parameter S_R, default 6'b000001, one-hot code of reset/idle state (nothing matched).
REQ-002 Parameter S_1, default 6'b000010, one-hot code of state "1 matched".
REQ-003 Parameter S_10, default 6'b000100, one-hot code of state "10 matched".
REQ-004 Parameter S_100, default 6'b001000, one-hot code of state "100 matched".
REQ-005 Parameter S_1001, default 6'b010000, one-hot code of state "1001 matched".
REQ-006 Parameter S_10010, default 6'b100000, one-hot code of state "10010 detected".
REQ-007 clk  input  1  single clock; all state changes on rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 in  input  1  serial data bit, sampled only when valid=1.
REQ-010 valid  input  1  qualifies in; one bit consumed per clock with valid=1.
REQ-011 out  output  1  detection flag, high exactly while state is S_10010.

Function
REQ-012 Block SHALL be a Moore FSM detecting serial pattern 1-0-0-1-0 (first bit earliest), non-overlapping by default.
REQ-013 State register SHALL be 6-bit one-hot using the S_* codes; out SHALL be decoded from state only (no combinational path from in or valid).
REQ-014 With valid=1, transitions SHALL be: S_R: 1->S_1, 0->S_R; S_1: 1->S_1, 0->S_10; S_10: 0->S_100, 1->S_1; S_100: 1->S_1001, 0->S_R; S_1001: 0->S_10010, 1->S_1; S_10010: 1->S_1, 0->S_R.
REQ-015 With valid=0, state SHALL hold and in SHALL be ignored (including X); out holds its value.
REQ-016 Latency: out SHALL rise on the clock edge that samples the fifth pattern bit and be visible the following cycle.
REQ-017 out SHALL stay high one cycle per detection when valid stays 1; it stays high longer only while valid=0 holds S_10010.
REQ-018 Non-overlap: bits of a detected pattern SHALL NOT be reused; the next detection requires five fresh bits after S_10010.
REQ-019 Any illegal (non-one-hot) state value SHALL return to S_R on the next edge.

Reset
REQ-020 When rst=1 at a rising clk edge, state SHALL become S_R and out 0, overriding valid and in.
REQ-021 Reset asserted mid-pattern SHALL discard partial match; no detection from bits preceding reset.
REQ-022 Without rst, initial state is undefined; rst SHALL be applied for at least one edge before use.

Configuration
REQ-023 Macro PATTERN_OVERLAP_EN: when defined, S_10010 transitions SHALL be 0->S_100, 1->S_1 (overlapping detection; "10010010" yields two hits); when undefined, REQ-014 non-overlapping transitions apply.

Structure
REQ-024 State codes S_R..S_10010 and a 6-bit state typedef SHALL live in shared package pattern_pkg; module parameters default from it.
REQ-025 Single module, no sub-modules: one sequential state block, one combinational next-state block, one output decode.

Verification
REQ-026 rst=1 two edges, valid=0, in=0 -> state S_R, out=0.
REQ-027 valid=1, in stream 1,0,0,1,0 -> out=1 for exactly one cycle after the fifth bit edge, then 0.
REQ-028 valid=1, stream 1,0,0,1,0,0,1,0 -> one detection without PATTERN_OVERLAP_EN; two with it.
REQ-029 stream 1,0,valid=0 for 3 cycles (in toggling),0,1,0 -> one detection; gaps ignored.
REQ-030 stream 1,0,0,1 then rst=1 one edge, then 0 -> out stays 0, state S_R.
REQ-031 500 random valid=1 bits -> rising-edge count of out equals count of non-overlapping 10010 occurrences from a reference model.
